// File: rtl/column_scanner.sv
// One-hot column driver with break-before-make blanking, scan direction,
// resync to column 0 and wrap reporting. All outputs are registered.
module column_scanner #(
  parameter int N_COLUMNS   = 8,
  parameter int DEAD_TIME   = 4,
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter int IDX_W       = $clog2(N_COLUMNS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 enable,
  input  logic                 column_ready,
  input  logic                 reverse,
  input  logic                 position_sync,
  output logic [N_COLUMNS-1:0] mux_out,
  output logic [IDX_W-1:0]     column_idx,
  output logic                 dead,
  output logic                 wrap
);

  localparam int CNT_W = (DEAD_TIME < 2) ? 1 : $clog2(DEAD_TIME + 1);
  localparam logic [IDX_W-1:0]     LAST     = IDX_W'(N_COLUMNS - 1);
  localparam logic [N_COLUMNS-1:0] INACTIVE = {N_COLUMNS{~ACTIVE_HIGH}};

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_nidx, w_nidx_nxt;
  logic                 r_nwrap, w_nwrap_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [N_COLUMNS-1:0] r_mux, w_mux_nxt;
  logic                 r_dead, w_dead_nxt;
  logic                 r_wrap, w_wrap_nxt;

  logic [IDX_W-1:0]     w_tgt, w_dead_idx;
  logic                 w_tgt_wrap, w_dead_wrap, w_adv;

  function automatic logic [N_COLUMNS-1:0] drive(input logic [IDX_W-1:0] idx);
    logic [N_COLUMNS-1:0] v;
    v = N_COLUMNS'(1) << idx;
    return ACTIVE_HIGH ? v : ~v;
  endfunction

  assign w_adv = column_ready | position_sync;

  // Successor column; sync overrides direction and never counts as a wrap.
  always_comb begin
    w_tgt      = '0;
    w_tgt_wrap = 1'b0;
    if (position_sync) begin
      w_tgt      = '0;
      w_tgt_wrap = 1'b0;
    end else if (reverse) begin
      w_tgt      = (r_idx == '0) ? LAST : r_idx - 1'b1;
      w_tgt_wrap = (r_idx == '0);
    end else begin
      w_tgt      = (r_idx == LAST) ? '0 : r_idx + 1'b1;
      w_tgt_wrap = (r_idx == LAST);
    end
  end

  // A sync seen while blanking retargets column 0 without restarting the count.
  assign w_dead_idx  = position_sync ? '0 : r_nidx;
  assign w_dead_wrap = position_sync ? 1'b0 : r_nwrap;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_nidx_nxt  = r_nidx;
    w_nwrap_nxt = r_nwrap;
    w_idx_nxt   = r_idx;
    w_mux_nxt   = INACTIVE;
    w_dead_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nidx_nxt  = '0;
          w_nwrap_nxt = 1'b0;
          if (DEAD_TIME == 0) begin
            w_state_nxt = S_ON;
            w_idx_nxt   = '0;
            w_mux_nxt   = drive('0);
          end else begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = CNT_W'(DEAD_TIME);
            w_dead_nxt  = 1'b1;
          end
        end
        S_DEAD: begin
          w_nidx_nxt  = w_dead_idx;
          w_nwrap_nxt = w_dead_wrap;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_ON;
            w_idx_nxt   = w_dead_idx;
            w_mux_nxt   = drive(w_dead_idx);
            w_wrap_nxt  = w_dead_wrap;
          end else begin
            w_dead_nxt  = 1'b1;
          end
        end
        S_ON: begin
          if (!w_adv) begin
            w_mux_nxt = drive(r_idx);
          end else if (DEAD_TIME == 0) begin
            w_idx_nxt  = w_tgt;
            w_mux_nxt  = drive(w_tgt);
            w_wrap_nxt = w_tgt_wrap;
          end else begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = CNT_W'(DEAD_TIME);
            w_nidx_nxt  = w_tgt;
            w_nwrap_nxt = w_tgt_wrap;
            w_dead_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_nidx  <= '0;
      r_nwrap <= 1'b0;
      r_idx   <= '0;
      r_mux   <= INACTIVE;
      r_dead  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_nidx  <= w_nidx_nxt;
      r_nwrap <= w_nwrap_nxt;
      r_idx   <= w_idx_nxt;
      r_mux   <= w_mux_nxt;
      r_dead  <= w_dead_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign mux_out    = r_mux;
  assign column_idx = r_idx;
  assign dead       = r_dead;
  assign wrap       = r_wrap;

endmodule
